// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with pointer-difference occupancy, threshold flags and optional FWFT read port.
// Define SYNC_FIFO_ERR_EN to enable the sticky overflow/underflow flags (tied low otherwise).
module sync_fifo_pro #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 4,
  parameter int AFULL_TH    = 14,
  parameter int AEMPTY_TH   = 2,
  parameter int FWFT        = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   w_en,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   r_en,
  output logic [DATA_WIDTH-1:0]  read_data,
  output logic                   read_valid,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   fill_count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_C  = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] PTR_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0] AFULL_C  = (DEPTH_WIDTH + 1)'(AFULL_TH);
  localparam logic [DEPTH_WIDTH:0] AEMPTY_C = (DEPTH_WIDTH + 1)'(AEMPTY_TH);

  generate
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH) || (AEMPTY_TH < 0) || (AEMPTY_TH >= DEPTH)) begin : g_param_check
      $error("sync_fifo_pro: AFULL_TH must be 1..DEPTH and AEMPTY_TH must be 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
  logic [DEPTH_WIDTH:0]   w_ptr_r;
  logic [DEPTH_WIDTH:0]   r_ptr_r;
  logic [DEPTH_WIDTH:0]   fill_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   wr_accept_s;
  logic                   rd_accept_s;

  // The extra pointer MSB distinguishes full from empty when the address bits match.
  assign fill_s      = w_ptr_r - r_ptr_r;
  assign full_s      = (fill_s == DEPTH_C);
  assign empty_s     = (w_ptr_r == r_ptr_r);
  assign wr_accept_s = w_en & ~full_s;
  assign rd_accept_s = r_en & ~empty_s;

  assign fill_count   = fill_s;
  assign fifo_full    = full_s;
  assign fifo_empty   = empty_s;
  assign almost_full  = (fill_s >= AFULL_C);
  assign almost_empty = (fill_s <= AEMPTY_C);

  // Pointer advance on accepted transfers; reset discards all stored words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_ptr_r <= {(DEPTH_WIDTH + 1){1'b0}};
      r_ptr_r <= {(DEPTH_WIDTH + 1){1'b0}};
    end else begin
      if (wr_accept_s) begin
        w_ptr_r <= w_ptr_r + PTR_ONE;
      end
      if (rd_accept_s) begin
        r_ptr_r <= r_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[w_ptr_r[DEPTH_WIDTH-1:0]] <= write_data;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] read_data_r;
      logic                  read_valid_r;

      // Registered pop: data lands one cycle after the accepted read and then holds.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          read_data_r  <= {DATA_WIDTH{1'b0}};
          read_valid_r <= 1'b0;
        end else begin
          read_valid_r <= rd_accept_s;
          if (rd_accept_s) begin
            read_data_r <= mem_r[r_ptr_r[DEPTH_WIDTH-1:0]];
          end
        end
      end

      assign read_data  = read_data_r;
      assign read_valid = read_valid_r;
    end else begin : g_fwft_read
      assign read_data  = mem_r[r_ptr_r[DEPTH_WIDTH-1:0]];
      assign read_valid = ~empty_s;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a new error in the clear cycle wins over err_clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= (w_en & full_s) | (overflow_r & ~err_clr);
      underflow_r <= (r_en & empty_s) | (underflow_r & ~err_clr);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Directed plus random test of sync_fifo_pro (registered-read and FWFT instances share stimulus)
// against a queue-based reference model.
module tb_sync_fifo_pro;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] write_data = 32'd0;

  logic [31:0] rd0, rd1;
  logic        rv0, rv1, full0, empty0, af0, ae0, ovf0, udf0;
  logic        full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0]  fc0, fc1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q[$];
  logic [31:0] exp_rd0 = 32'd0;
  logic        exp_rv0 = 1'b0;
  logic        exp_ovf = 1'b0;
  logic        exp_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_pro #(.FWFT(0)) dut0 (
    .clk(clk), .rstn(rstn), .w_en(w_en), .write_data(write_data), .r_en(r_en),
    .read_data(rd0), .read_valid(rv0), .fifo_full(full0), .fifo_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .fill_count(fc0),
    .overflow(ovf0), .underflow(udf0), .err_clr(err_clr));

  sync_fifo_pro #(.FWFT(1)) dut1 (
    .clk(clk), .rstn(rstn), .w_en(w_en), .write_data(write_data), .r_en(r_en),
    .read_data(rd1), .read_valid(rv1), .fifo_full(full1), .fifo_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .fill_count(fc1),
    .overflow(ovf1), .underflow(udf1), .err_clr(err_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("fill_count", 32'(fc0), 32'(n));
    chk("fifo_full", 32'(full0), 32'(n == 16));
    chk("fifo_empty", 32'(empty0), 32'(n == 0));
    chk("almost_full", 32'(af0), 32'(n >= 14));
    chk("almost_empty", 32'(ae0), 32'(n <= 2));
    chk("read_valid", 32'(rv0), 32'(exp_rv0));
    chk("read_data", rd0, exp_rd0);
    chk("overflow", 32'(ovf0), 32'(exp_ovf));
    chk("underflow", 32'(udf0), 32'(exp_udf));
    chk("fwft_fill_count", 32'(fc1), 32'(n));
    chk("fwft_read_valid", 32'(rv1), 32'(n != 0));
    if (n != 0) chk("fwft_read_data", rd1, q[0]);
  endtask

  // One clock of stimulus: model decides acceptance from the pre-edge occupancy.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r, input logic c);
    bit was_full, was_empty;
    w_en = w; write_data = d; r_en = r; err_clr = c;
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    @(posedge clk);
    #1;
    exp_rv0 = 1'b0;
    if (r && !was_empty) begin
      exp_rd0 = q.pop_front();
      exp_rv0 = 1'b1;
    end
    if (w && !was_full) q.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
    exp_ovf = (w && was_full) || (exp_ovf && !c);
    exp_udf = (r && was_empty) || (exp_udf && !c);
`endif
    check_all();
  endtask

  initial begin
    #12;
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    chk("fill_full_count", 32'(fc0), 32'd16);
    cycle(1'b1, 32'h0000_0099, 1'b0, 1'b0);
    chk("fill_drop_count", 32'(fc0), 32'd16);

    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("drain_data", rd0, 32'(i));
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    chk("drain_hold", rd0, 32'h0000_000F);
    chk("drain_no_valid", 32'(rv0), 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b1, 1'b0);
    chk("simul_count", 32'(fc0), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("simul_full_count", 32'(fc0), 32'd15);

    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    chk("drained_empty", 32'(empty0), 32'd1);

    cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    chk("fwft_a5", rd1, 32'hA5A5_A5A5);
    chk("fwft_a5_valid", 32'(rv1), 32'd1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    #1 rstn = 1'b0;
    #1;
    q.delete();
    exp_rd0 = 32'd0; exp_rv0 = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_all();
    chk("reset_fwft_valid", 32'(rv1), 32'd0);
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    rstn = 1'b1;
    cycle(1'b1, 32'h0000_1234, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    chk("post_reset_first", rd0, 32'h0000_1234);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
